// File: rtl/usage_sampler.sv
// usage_sampler: gates a usage counter over a timed window and captures its count, once or back-to-back.
module usage_sampler #(
  parameter int COUNTER_WIDTH = 16,
  parameter int WINDOW_WIDTH  = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     sysclk,
  input  logic                     sysreset,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     stop,
  input  logic [WINDOW_WIDTH-1:0]  window_len,
  output logic                     sample_enable,
  output logic                     counter_reset,
  input  logic [COUNTER_WIDTH-1:0] counter_in,
  output logic [COUNTER_WIDTH-1:0] result,
  output logic                     result_valid,
  input  logic                     result_ack,
  output logic                     overrun,
  output logic                     busy
);
  typedef enum logic [2:0] {IDLE, CLEAR, WINDOW, SETTLE, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [WINDOW_WIDTH-1:0]  len_q, len_d, win_q, win_d;
  logic [3:0]               set_q, set_d;
  logic [COUNTER_WIDTH-1:0] res_q, res_d;
  logic cont_q, cont_d, stop_q, stop_d;
  logic se_q, se_d, cr_q, cr_d, busy_q, busy_d, rv_q, rv_d, ov_q, ov_d;
  logic accept, cap;
  assign accept = (state_q == IDLE) && start;
  assign cap    = (state_q == CAPTURE);
  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      state_q <= IDLE;
      len_q   <= '0;
      win_q   <= '0;
      set_q   <= '0;
      res_q   <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      se_q    <= 1'b0;
      cr_q    <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      win_q   <= win_d;
      set_q   <= set_d;
      res_q   <= res_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      se_q    <= se_d;
      cr_q    <= cr_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      ov_q    <= ov_d;
    end
  end
  // A stop seen during the capture cycle itself ends the run at that capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? CLEAR : IDLE;
      CLEAR:   state_d = WINDOW;
      WINDOW:  state_d = (win_q == '0) ? SETTLE : WINDOW;
      SETTLE:  state_d = (set_q == '0) ? CAPTURE : SETTLE;
      CAPTURE: state_d = (cont_q && !stop_q && !stop) ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Output flops are loaded from the next state so they line up with it.
  always_comb begin
    len_d  = accept ? ((window_len == '0) ? WINDOW_WIDTH'(1) : window_len) : len_q;
    cont_d = accept ? continuous : cont_q;
    stop_d = accept ? 1'b0 : ((stop && state_q != IDLE) ? 1'b1 : stop_q);
    win_d  = (state_q == CLEAR) ? len_q - 1'b1 : (state_q == WINDOW) ? win_q - 1'b1 : win_q;
    set_d  = (state_q == WINDOW) ? 4'(SETTLE_CYCLES - 1) : (state_q == SETTLE) ? set_q - 4'd1 : set_q;
    res_d  = cap ? counter_in : res_q;
    rv_d   = cap || (rv_q && !result_ack);
    ov_d   = accept ? 1'b0 : (ov_q || (cap && rv_q && !result_ack));
    se_d   = (state_d == WINDOW);
    cr_d   = (state_d == CLEAR);
    busy_d = (state_d != IDLE);
  end
  assign sample_enable = se_q;
  assign counter_reset = cr_q;
  assign result        = res_q;
  assign result_valid  = rv_q;
  assign overrun       = ov_q;
  assign busy          = busy_q;
endmodule
